// File: rtl/class_pkg.sv
// Shared encodings, FSM state type and default sizing for the classification
// hash-table memory arbiter (class_mem_arb, class_mem_rd_pipe).
package class_pkg;

    localparam int DEF_ADDR_W       = 12;
    localparam int DEF_RD_LAT       = 2;
    localparam int DEF_STARVE_LIMIT = 8;

    localparam logic PIO_RD = 1'b1;
    localparam logic PIO_WR = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } pio_arb_state_t;

    typedef enum logic {
        OWN_LU  = 1'b0,
        OWN_PIO = 1'b1
    } rd_owner_t;

endpackage

// File: rtl/class_mem_rd_pipe.sv
// Read-return tracker: shifts a valid bit and owner tag for RD_LAT cycles so each
// memory read can be steered back to the lookup path or the PIO path.
module class_mem_rd_pipe
    import class_pkg::*;
#(
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      in_vld,
    input  rd_owner_t in_owner,
    output logic      out_vld,
    output rd_owner_t out_owner
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] own_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            own_q[0] <= in_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
            end
        end
    end

    assign out_vld   = vld_q[RD_LAT-1];
    assign out_owner = rd_owner_t'(own_q[RD_LAT-1]);

endmodule

// File: rtl/class_mem_arb.sv
// Shares one pipelined hash-table memory port between the lookup pipeline and PIO.
// Define CLASS_MEM_ARB_STARVE_EN to bound how long lookup traffic can starve PIO.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no PIO access in flight; lookups own the port
// ST_ISSUE | PIO access is the port winner this cycle, lookups blocked
// ST_WAIT  | PIO read in flight, down-counting to data return
// ST_ACK   | mem_pio_ack pulse; mem_dout holds read data
module class_mem_arb
    import class_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RD_LAT       = DEF_RD_LAT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lu_req,
    input  logic [ADDR_W-1:0] lu_addr,
    output logic              lu_gnt,
    output logic              lu_rvalid,
    output logic [31:0]       lu_rdata,
    input  logic              pio_mem_req,
    input  logic              pio_mem_rd_wr,
    input  logic [ADDR_W-1:0] pio_mem_addr,
    input  logic [31:0]       pio_mem_din,
    output logic              mem_pio_ack,
    output logic [31:0]       mem_dout,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    if (RD_LAT < 1 || RD_LAT > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
        $error("class_mem_arb: RD_LAT must be 1..4 and STARVE_LIMIT 1..255");
    end

    pio_arb_state_t state_q, state_d;
    logic [2:0]     wait_cnt_q, wait_cnt_d;
    logic           pio_win;
    logic           starved;
    logic           wait_done;
    logic           nxt_en;
    logic           nxt_wr;
    logic           pipe_vld;
    rd_owner_t      pipe_owner;
    logic           lu_ret;

`ifdef CLASS_MEM_ARB_STARVE_EN
    logic [7:0] starve_cnt_q, starve_cnt_d;

    assign starved = (state_q == ST_IDLE) && pio_mem_req && (starve_cnt_q == 8'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!pio_mem_req || (state_q == ST_IDLE && state_d == ST_ISSUE)) begin
            starve_cnt_d = '0;
        end else if (state_q == ST_IDLE && lu_gnt && starve_cnt_q != 8'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starved = 1'b0;
`endif

    assign pio_win     = (state_q == ST_ISSUE);
    assign lu_gnt      = lu_req && !pio_win && !starved && !rst;
    assign wait_done   = (state_q == ST_WAIT) && (wait_cnt_q == 3'd0);
    assign mem_pio_ack = (state_q == ST_ACK);
    assign nxt_en      = pio_win || lu_gnt;
    assign nxt_wr      = pio_win && (pio_mem_rd_wr == PIO_WR);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pio_mem_req && (!lu_req || starved)) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (pio_mem_rd_wr == PIO_RD) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 3'(RD_LAT - 1);
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 3'd0) state_d = ST_ACK;
                else                    wait_cnt_d = wait_cnt_q - 3'd1;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Port registers hold address/data between accesses to avoid needless toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= nxt_en;
            mem_wr <= nxt_wr;
            if (nxt_en) mem_addr  <= pio_win ? pio_mem_addr : lu_addr;
            if (nxt_wr) mem_wdata <= pio_mem_din;
        end
    end

    class_mem_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (nxt_en && !nxt_wr),
        .in_owner  (pio_win ? OWN_PIO : OWN_LU),
        .out_vld   (pipe_vld),
        .out_owner (pipe_owner)
    );

    assign lu_ret = pipe_vld && (pipe_owner == OWN_LU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_rvalid <= 1'b0;
            lu_rdata  <= '0;
            mem_dout  <= '0;
        end else begin
            lu_rvalid <= lu_ret;
            if (lu_ret)    lu_rdata <= mem_rdata;
            if (wait_done) mem_dout <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_class_mem_arb.sv
// Directed bench for class_mem_arb with a one-cycle synchronous SRAM model (RD_LAT=2).
module tb_class_mem_arb;
    import class_pkg::*;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              lu_req;
    logic [ADDR_W-1:0] lu_addr;
    logic              lu_gnt;
    logic              lu_rvalid;
    logic [31:0]       lu_rdata;
    logic              pio_mem_req;
    logic              pio_mem_rd_wr;
    logic [ADDR_W-1:0] pio_mem_addr;
    logic [31:0]       pio_mem_din;
    logic              mem_pio_ack;
    logic [31:0]       mem_dout;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem_model [0:(1<<ADDR_W)-1];
    logic [31:0] rdata_q = '0;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    class_mem_arb #(
        .ADDR_W       (ADDR_W),
        .RD_LAT       (2),
        .STARVE_LIMIT (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lu_req        (lu_req),
        .lu_addr       (lu_addr),
        .lu_gnt        (lu_gnt),
        .lu_rvalid     (lu_rvalid),
        .lu_rdata      (lu_rdata),
        .pio_mem_req   (pio_mem_req),
        .pio_mem_rd_wr (pio_mem_rd_wr),
        .pio_mem_addr  (pio_mem_addr),
        .pio_mem_din   (pio_mem_din),
        .mem_pio_ack   (mem_pio_ack),
        .mem_dout      (mem_dout),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) mem_model[mem_addr] <= mem_wdata;
            else        rdata_q <= mem_model[mem_addr];
        end
    end
    assign mem_rdata = rdata_q;

    function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
        return 32'h5000_0000 | 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; checks follow at the falling edge.
    task automatic drive(input logic lr, input logic [ADDR_W-1:0] la, input logic pr,
                         input logic rw, input logic [ADDR_W-1:0] pa, input logic [31:0] pd);
        @(posedge clk);
        #1;
        lu_req        = lr;
        lu_addr       = la;
        pio_mem_req   = pr;
        pio_mem_rd_wr = rw;
        pio_mem_addr  = pa;
        pio_mem_din   = pd;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, PIO_RD, '0, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    32'(lu_gnt),      32'd0);
        chk({tag, "_rvalid"}, 32'(lu_rvalid),   32'd0);
        chk({tag, "_rdata"},  lu_rdata,         32'd0);
        chk({tag, "_ack"},    32'(mem_pio_ack), 32'd0);
        chk({tag, "_dout"},   mem_dout,         32'd0);
        chk({tag, "_en"},     32'(mem_en),      32'd0);
        chk({tag, "_wr"},     32'(mem_wr),      32'd0);
        chk({tag, "_addr"},   32'(mem_addr),    32'd0);
        chk({tag, "_wdata"},  mem_wdata,        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) mem_model[i] = pat(ADDR_W'(i));
        rst = 1'b1;
        lu_req = 1'b0; lu_addr = '0; pio_mem_req = 1'b0;
        pio_mem_rd_wr = PIO_RD; pio_mem_addr = '0; pio_mem_din = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        @(posedge clk);
        #1 rst = 1'b0;

        // PIO write with the port otherwise idle
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h010, 32'hA5A5_A5A5);
        chk("wr_c0_ack", 32'(mem_pio_ack), 32'd0);
        chk("wr_c0_en",  32'(mem_en), 32'd0);
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h010, 32'hA5A5_A5A5);
        chk("wr_c1_en",  32'(mem_en), 32'd0);
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h010, 32'hA5A5_A5A5);
        chk("wr_c2_ack",   32'(mem_pio_ack), 32'd1);
        chk("wr_c2_en",    32'(mem_en), 32'd1);
        chk("wr_c2_wr",    32'(mem_wr), 32'd1);
        chk("wr_c2_addr",  32'(mem_addr), 32'h010);
        chk("wr_c2_wdata", mem_wdata, 32'hA5A5_A5A5);
        idle();
        chk("wr_c3_ack", 32'(mem_pio_ack), 32'd0);
        chk("wr_c3_en",  32'(mem_en), 32'd0);

        // PIO read of the same address with lookups streaming during WAIT/ACK
        drive(1'b0, '0, 1'b1, PIO_RD, 12'h010, '0);
        drive(1'b0, '0, 1'b1, PIO_RD, 12'h010, '0);
        chk("rd_c1_en", 32'(mem_en), 32'd0);
        drive(1'b1, 12'h100, 1'b1, PIO_RD, 12'h010, '0);
        chk("rd_c2_gnt",  32'(lu_gnt), 32'd1);
        chk("rd_c2_en",   32'(mem_en), 32'd1);
        chk("rd_c2_wr",   32'(mem_wr), 32'd0);
        chk("rd_c2_addr", 32'(mem_addr), 32'h010);
        drive(1'b1, 12'h101, 1'b1, PIO_RD, 12'h010, '0);
        chk("rd_c3_gnt", 32'(lu_gnt), 32'd1);
        chk("rd_c3_ack", 32'(mem_pio_ack), 32'd0);
        drive(1'b1, 12'h102, 1'b1, PIO_RD, 12'h010, '0);
        chk("rd_c4_gnt",    32'(lu_gnt), 32'd1);
        chk("rd_c4_ack",    32'(mem_pio_ack), 32'd1);
        chk("rd_c4_dout",   mem_dout, 32'hA5A5_A5A5);
        chk("rd_c4_rvalid", 32'(lu_rvalid), 32'd0);
        idle();
        chk("rd_c5_ack",    32'(mem_pio_ack), 32'd0);
        chk("rd_c5_rvalid", 32'(lu_rvalid), 32'd1);
        chk("rd_c5_rdata",  lu_rdata, pat(12'h100));
        idle();
        chk("rd_c6_rvalid", 32'(lu_rvalid), 32'd1);
        chk("rd_c6_rdata",  lu_rdata, pat(12'h101));
        idle();
        chk("rd_c7_rvalid", 32'(lu_rvalid), 32'd1);
        chk("rd_c7_rdata",  lu_rdata, pat(12'h102));
        idle();
        chk("rd_c8_rvalid", 32'(lu_rvalid), 32'd0);

        // Write then lookup read of the same address sees the new data
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h020, 32'h1234_5678);
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h020, 32'h1234_5678);
        drive(1'b1, 12'h020, 1'b1, PIO_WR, 12'h020, 32'h1234_5678);
        chk("raw_c2_ack", 32'(mem_pio_ack), 32'd1);
        chk("raw_c2_gnt", 32'(lu_gnt), 32'd1);
        idle();
        idle();
        chk("raw_c4_rvalid", 32'(lu_rvalid), 32'd0);
        idle();
        chk("raw_c5_rvalid", 32'(lu_rvalid), 32'd1);
        chk("raw_c5_rdata",  lu_rdata, 32'h1234_5678);
        chk("raw_c5_dout",   mem_dout, 32'hA5A5_A5A5);

        // Request held straight after ACK is a new request; ISSUE blocks lookups
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h030, 32'hD100_0030);
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h030, 32'hD100_0030);
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h030, 32'hD100_0030);
        chk("b2b_c2_ack", 32'(mem_pio_ack), 32'd1);
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h031, 32'hD200_0031);
        chk("b2b_c3_ack", 32'(mem_pio_ack), 32'd0);
        drive(1'b1, 12'h300, 1'b1, PIO_WR, 12'h031, 32'hD200_0031);
        chk("b2b_c4_issue_gnt", 32'(lu_gnt), 32'd0);
        chk("b2b_c4_ack", 32'(mem_pio_ack), 32'd0);
        drive(1'b0, '0, 1'b1, PIO_WR, 12'h031, 32'hD200_0031);
        chk("b2b_c5_ack",   32'(mem_pio_ack), 32'd1);
        chk("b2b_c5_addr",  32'(mem_addr), 32'h031);
        chk("b2b_c5_wdata", mem_wdata, 32'hD200_0031);
        idle();

        // Continuous lookup traffic against a held PIO write
`ifdef CLASS_MEM_ARB_STARVE_EN
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 12'(12'h200 + i), (i <= 10), PIO_WR, 12'h040, 32'hBEEF_0040);
            chk($sformatf("stv_c%0d_gnt", i), 32'(lu_gnt), 32'((i == 8 || i == 9) ? 0 : 1));
            chk($sformatf("stv_c%0d_ack", i), 32'(mem_pio_ack), 32'(i == 10));
            if (i == 10) begin
                chk("stv_c10_wr",   32'(mem_wr), 32'd1);
                chk("stv_c10_addr", 32'(mem_addr), 32'h040);
            end
        end
`else
        for (int i = 0; i < 16; i++) begin
            drive((i < 12), 12'(12'h200 + i), (i <= 14), PIO_WR, 12'h040, 32'hBEEF_0040);
            chk($sformatf("strict_c%0d_gnt", i), 32'(lu_gnt), 32'(i < 12));
            chk($sformatf("strict_c%0d_ack", i), 32'(mem_pio_ack), 32'(i == 14));
            if (i == 14) begin
                chk("strict_c14_wr",   32'(mem_wr), 32'd1);
                chk("strict_c14_addr", 32'(mem_addr), 32'h040);
            end
        end
`endif
        repeat (4) idle();

        // Reset in the middle of a PIO read with a lookup read in flight
        drive(1'b0, '0, 1'b1, PIO_RD, 12'h010, '0);
        drive(1'b0, '0, 1'b1, PIO_RD, 12'h010, '0);
        drive(1'b1, 12'h100, 1'b1, PIO_RD, 12'h010, '0);
        chk("mrst_c2_gnt", 32'(lu_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        lu_req = 1'b0; pio_mem_req = 1'b0;
        @(negedge clk);
        chk_all_zero("mrst");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            chk($sformatf("post_rst_%0d_ack", i),    32'(mem_pio_ack), 32'd0);
            chk($sformatf("post_rst_%0d_rvalid", i), 32'(lu_rvalid), 32'd0);
            chk($sformatf("post_rst_%0d_en", i),     32'(mem_en), 32'd0);
        end
        chk("post_rst_dout", mem_dout, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
